// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, halt encoding and the fetch FSM state type for the fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 9;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode output slot plus execute redirect request, shared between fetch and its consumers.
interface fetch_sequencer_if #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
);

    // Slot transfer happens on a rising edge where instr_valid & instr_ready; while
    // instr_valid is high and instr_ready low, instr/instr_pc must not change.
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;

    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  br_taken,
        input  br_target
    );

    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output br_taken,
        output br_target
    );

endinterface

// File: rtl/fetch_sequencer_perf_cnt.sv
// Saturating fetch/flush/stall event counters; only built when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_fetch_inc,
    input  logic        i_flush_inc,
    input  logic        i_stall_inc,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Each counter sticks at all-ones instead of wrapping.
            if (i_fetch_inc && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (i_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
            if (i_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch controller in front of a combinational ROM, with branch flush and halt drain.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / flush_cnt / stall_cnt outputs.
module fetch_sequencer #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_INSTR = fetch_pkg::HALT_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [INSTR_W-1:0]     rom_data,
    fetch_sequencer_if.master      dec,
    output logic                   busy,
    output logic                   done,
    output fetch_pkg::fetch_state_t dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            flush_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    import fetch_pkg::*;

    fetch_state_t       r_state, w_state_n;
    logic [ADDR_W-1:0]  r_pc, w_pc_n;
    logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_n;
    logic [INSTR_W-1:0] r_instr, w_instr_n;
    logic               r_valid, w_valid_n;
    logic               r_busy;
    logic               r_done;
    logic               w_load_ok;

    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_instr_n    = r_instr;
        w_instr_pc_n = r_instr_pc;
        w_valid_n    = r_valid;
        w_load_ok    = !r_valid || dec.instr_ready;

        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_pc_n    = start_addr;
                    w_state_n = RUN;
                end
            end
            RUN: begin
                // A redirect always beats a load, even when decode is taking the slot.
                if (dec.br_taken) begin
                    w_valid_n = 1'b0;
                    w_pc_n    = dec.br_target;
                end else if (w_load_ok) begin
                    w_instr_n    = rom_data;
                    w_instr_pc_n = r_pc;
                    w_valid_n    = 1'b1;
                    if (rom_data == HALT_INSTR) w_state_n = DRAIN;
                    else                        w_pc_n    = r_pc + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (dec.br_taken) begin
                    w_valid_n = 1'b0;
                    w_pc_n    = dec.br_target;
                    w_state_n = RUN;
                end else if (r_valid && dec.instr_ready) begin
                    w_valid_n = 1'b0;
                    w_state_n = HALT;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_instr    <= w_instr_n;
            r_instr_pc <= w_instr_pc_n;
            r_valid    <= w_valid_n;
            r_busy     <= (w_state_n == RUN) || (w_state_n == DRAIN);
            r_done     <= (w_state_n == HALT);
        end
    end

    assign rom_addr        = r_pc;
    assign dec.instr       = r_instr;
    assign dec.instr_pc    = r_instr_pc;
    assign dec.instr_valid = r_valid;
    assign busy            = r_busy;
    assign done            = r_done;
    assign dbg_state       = r_state;

`ifdef FETCH_PERF_CNT_EN
    logic w_start_ok;
    logic w_fetch_inc;
    logic w_flush_inc;
    logic w_stall_inc;

    assign w_start_ok  = ((r_state == IDLE) || (r_state == HALT)) && start;
    assign w_fetch_inc = (r_state == RUN) && !dec.br_taken && w_load_ok;
    assign w_flush_inc = ((r_state == RUN) || (r_state == DRAIN)) && dec.br_taken && r_valid;
    assign w_stall_inc = (r_state == RUN) && r_valid && !dec.instr_ready;

    fetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_start_ok),
        .i_fetch_inc (w_fetch_inc),
        .i_flush_inc (w_flush_inc),
        .i_stall_inc (w_stall_inc),
        .o_fetch_cnt (fetch_cnt),
        .o_flush_cnt (flush_cnt),
        .o_stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized phase against a behavioural model.
module tb_fetch_sequencer;

    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  start_addr;
    logic [15:0]  rom_addr;
    logic [8:0]   rom_data;
    logic         busy;
    logic         done;
    fetch_state_t dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  fetch_cnt;
    logic [31:0]  flush_cnt;
    logic [31:0]  stall_cnt;
`endif

    fetch_sequencer_if dec_if ();

    logic [8:0] rom [0:65535];
    assign rom_data = rom[rom_addr];

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dec        (dec_if.master),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .flush_cnt  (flush_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    fetch_state_t m_state = IDLE;
    int unsigned  m_pc = 0;
    bit           m_valid = 0;
    int unsigned  m_word = 0;
    int unsigned  m_wpc = 0;
    longint       m_fetch = 0, m_flush = 0, m_stall = 0;
    localparam longint SAT = 64'hFFFF_FFFF;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = IDLE; m_pc = 0; m_valid = 0; m_word = 0; m_wpc = 0;
            m_fetch = 0; m_flush = 0; m_stall = 0;
        end else if (m_state == IDLE || m_state == HALT) begin
            if (start) begin
                m_pc = start_addr; m_state = RUN;
                m_fetch = 0; m_flush = 0; m_stall = 0;
            end
        end else if (m_state == RUN) begin
            if (m_valid && !dec_if.instr_ready && m_stall < SAT) m_stall++;
            if (dec_if.br_taken) begin
                if (m_valid && m_flush < SAT) m_flush++;
                m_valid = 0; m_pc = dec_if.br_target;
            end else if (!m_valid || dec_if.instr_ready) begin
                if (m_fetch < SAT) m_fetch++;
                m_word = rom[m_pc]; m_wpc = m_pc; m_valid = 1;
                if (m_word == 32'h1FF) m_state = DRAIN;
                else m_pc = (m_pc + 1) % 65536;
            end
        end else begin
            if (dec_if.br_taken) begin
                if (m_valid && m_flush < SAT) m_flush++;
                m_valid = 0; m_pc = dec_if.br_target; m_state = RUN;
            end else if (dec_if.instr_ready) begin
                m_valid = 0; m_state = HALT;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_rom_addr", rom_addr, m_pc);
            cmp("m_valid", dec_if.instr_valid, m_valid);
            cmp("m_state", 32'(dbg_state), 32'(m_state));
            cmp("m_busy", busy, (m_state == RUN || m_state == DRAIN));
            cmp("m_done", done, (m_state == HALT));
            if (m_valid) begin
                cmp("m_instr", dec_if.instr, m_word);
                cmp("m_instr_pc", dec_if.instr_pc, m_wpc);
            end
`ifdef FETCH_PERF_CNT_EN
            cmp("m_fetch_cnt", fetch_cnt, 32'(m_fetch));
            cmp("m_flush_cnt", flush_cnt, 32'(m_flush));
            cmp("m_stall_cnt", stall_cnt, 32'(m_stall));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    logic [24:0] exp_q[$];
    logic [24:0] got_q[$];

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic start_at(input logic [15:0] a);
        start = 1'b1;
        start_addr = a;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (dec_if.instr_valid && dec_if.instr_ready) got_q.push_back({dec_if.instr_pc, dec_if.instr});
            cyc();
        end
    endtask

    task automatic exp_push(input logic [15:0] pc, input logic [8:0] w);
        exp_q.push_back({pc, w});
    endtask

    task automatic expect_straight();
        exp_push(16'h0010, 9'h001);
        exp_push(16'h0011, 9'h002);
        exp_push(16'h0012, 9'h003);
        exp_push(16'h0013, 9'h1FF);
    endtask

    task automatic cmp_q(input string nm);
        int n;
        cmp({nm, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) cmp({nm, "_word"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_halt_in_slot(input int max_cyc);
        int k;
        k = 0;
        while (!(dec_if.instr_valid && dec_if.instr == 9'h1FF) && k < max_cyc) begin
            cyc();
            k++;
        end
        if (k >= max_cyc) cmp("halt_wait_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0;
        dec_if.instr_ready = 1'b0; dec_if.br_taken = 1'b0; dec_if.br_target = '0;
        for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom_range(0, 510));
        rom[16'h0010] = 9'h001; rom[16'h0011] = 9'h002;
        rom[16'h0012] = 9'h003; rom[16'h0013] = 9'h1FF;
        rom[16'h0020] = 9'h033; rom[16'h0040] = 9'h055;
        rom[16'hFFFF] = 9'h00A; rom[16'h0000] = 9'h00B; rom[16'h0001] = 9'h1FF;

        do_reset();
        chk_en = 1'b1;
        cmp("rst_valid", dec_if.instr_valid, 1'b0);
        cmp("rst_rom_addr", rom_addr, 16'h0000);
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_done", done, 1'b0);
        cmp("rst_instr", dec_if.instr, 9'h000);
        cmp("rst_instr_pc", dec_if.instr_pc, 16'h0000);

        // straight-line program
        dec_if.instr_ready = 1'b1;
        start_at(16'h0010);
        run_collect(8);
        expect_straight();
        cmp_q("straight");
        cmp("sl_done", done, 1'b1);
        cmp("sl_busy", busy, 1'b0);
        cmp("sl_pc", rom_addr, 16'h0013);

        // backpressure: hold the first word for 3 cycles
        start_at(16'h0010);
        cyc();
        dec_if.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            cmp("bp_instr", dec_if.instr, 9'h001);
            cmp("bp_instr_pc", dec_if.instr_pc, 16'h0010);
            cmp("bp_pc", rom_addr, 16'h0011);
        end
        dec_if.instr_ready = 1'b1;
        run_collect(8);
        expect_straight();
        cmp_q("backpressure");

        // redirect while the slot holds pc 0x11
        start_at(16'h0010);
        cyc();
        cyc();
        cmp("rd_pre_pc", dec_if.instr_pc, 16'h0011);
        dec_if.br_taken = 1'b1; dec_if.br_target = 16'h0040;
        cyc();
        dec_if.br_taken = 1'b0;
        cmp("rd_bubble", dec_if.instr_valid, 1'b0);
        cmp("rd_addr", rom_addr, 16'h0040);
        cyc();
        cmp("rd_valid", dec_if.instr_valid, 1'b1);
        cmp("rd_instr", dec_if.instr, 9'h055);
        cmp("rd_instr_pc", dec_if.instr_pc, 16'h0040);
        do_reset();

        // branch over the halt while draining, with decode ready
        start_at(16'h0010);
        wait_halt_in_slot(20);
        cmp("bh_state_drain", 32'(dbg_state), 32'(DRAIN));
        dec_if.br_taken = 1'b1; dec_if.br_target = 16'h0020;
        cyc();
        dec_if.br_taken = 1'b0;
        cmp("bh_state_run", 32'(dbg_state), 32'(RUN));
        cmp("bh_valid", dec_if.instr_valid, 1'b0);
        cmp("bh_addr", rom_addr, 16'h0020);
        cmp("bh_done", done, 1'b0);
        cyc();
        cmp("bh_instr", dec_if.instr, 9'h033);
        cmp("bh_instr_pc", dec_if.instr_pc, 16'h0020);
        do_reset();

        // PC wrap
        start_at(16'hFFFF);
        run_collect(6);
        exp_push(16'hFFFF, 9'h00A);
        exp_push(16'h0000, 9'h00B);
        exp_push(16'h0001, 9'h1FF);
        cmp_q("wrap");

        // reset mid-run with a pending slot, then restart
        start_at(16'h0010);
        dec_if.instr_ready = 1'b0;
        cyc();
        cmp("rs_pre_valid", dec_if.instr_valid, 1'b1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cmp("rs_valid", dec_if.instr_valid, 1'b0);
        cmp("rs_state", 32'(dbg_state), 32'(IDLE));
        cmp("rs_pc", rom_addr, 16'h0000);
        cmp("rs_done", done, 1'b0);
        cmp("rs_busy", busy, 1'b0);
        dec_if.instr_ready = 1'b1;
        start_at(16'h0010);
        run_collect(8);
        expect_straight();
        cmp_q("restart");
`ifdef FETCH_PERF_CNT_EN
        cmp("pc_fetch", fetch_cnt, 32'd4);
        cmp("pc_flush", flush_cnt, 32'd0);
        cmp("pc_stall", stall_cnt, 32'd0);
`endif

        // randomized phase
        for (int i = 16'h50; i < 16'h80; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            start_addr = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                     : 16'($urandom_range(16'h20, 16'h7F));
            dec_if.br_taken = ($urandom_range(0, 9) == 0);
            dec_if.br_target = 16'($urandom_range(16'h20, 16'h7F));
            dec_if.instr_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst_n = 1'b1; start = 1'b0; dec_if.br_taken = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer and fetch controller in front of the combinational instruction ROM (16-bit address, 9-bit word).
- Holds the PC and drives the ROM address. Captures the returned word into a registered valid/ready output slot for decode.
- Handles branch redirects with flush.
- Detects the halt encoding, drains the halt instruction to decode, then parks.

Parameters:
- ADDR_W, 16, PC / ROM address width.
- INSTR_W, 9, instruction width.
- HALT_INSTR, 9'h1FF, encoding that ends fetching.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin fetching at start_addr; honoured only in IDLE/HALT.
- start_addr  input  ADDR_W  first PC after start.
- rom_addr  output  ADDR_W  address to ROM; always equals pc.
- rom_data  input  INSTR_W  ROM word at rom_addr, same cycle.
- instr  output  INSTR_W  registered instruction to decode.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  output slot holds a live instruction.
- instr_ready  input  1  decode accepts; transfer = instr_valid & instr_ready.
- br_taken  input  1  redirect request from execute (flush).
- br_target  input  ADDR_W  absolute redirect address.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is HALT.

Behaviour:
- Single clock, synchronous active-low reset (rst_n sampled on rising clk).
- Reset values:
  - state=IDLE, pc=0, instr=0, instr_pc=0.
  - instr_valid=0, busy=0, done=0.
  - Reset mid-operation discards everything, including a pending slot.
- States:
  - IDLE: start -> pc<=start_addr, RUN.
  - RUN:
    - Slot may load when load_ok = !instr_valid | instr_ready.
    - Priority 1, br_taken: instr_valid<=0 (flush, even if instr_ready), pc<=br_target, no load this cycle.
    - Priority 2, load_ok: instr<=rom_data, instr_pc<=pc, instr_valid<=1.
      - rom_data != HALT_INSTR: pc<=pc+1, mod 2^ADDR_W (0xFFFF -> 0x0000).
      - rom_data == HALT_INSTR: pc unchanged, -> DRAIN.
    - Otherwise (slot full, not ready): hold everything (stall); pc stable, so rom_addr stable.
  - DRAIN:
    - Priority 1, br_taken: flush slot, pc<=br_target, -> RUN (a branch over the halt wins).
    - Priority 2, transfer: instr_valid<=0, -> HALT.
  - HALT: done=1. start -> pc<=start_addr, -> RUN, done<=0.
- start in RUN/DRAIN is ignored. br_taken in IDLE/HALT is ignored.
- busy and done are registered, decoded from state.
- Latency:
  - start at edge t -> first instr_valid after edge t+1.
  - Redirect at edge t -> target word valid after edge t+1 (1 bubble).
- Throughput: 1 instr/cycle with instr_ready held high.
- Outputs instr/instr_pc are stable while instr_valid & !instr_ready (no change under backpressure).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds three outputs:
  - fetch_cnt [31:0]: slot loads.
  - flush_cnt [31:0]: br_taken cycles that discarded a valid slot.
  - stall_cnt [31:0]: RUN cycles with instr_valid & !instr_ready.
- All counters cleared by reset and by an accepted start; they saturate at 2^32-1.
- When undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W, INSTR_W, HALT_INSTR default.
  - fetch_state_t enum {IDLE, RUN, DRAIN, HALT}.
- One natural sub-module, fetch_perf_cnt: three saturating counters, instantiated only under FETCH_PERF_CNT_EN.
- FSM, PC and output slot stay in fetch_sequencer.

Test Plan:
- Straight-line: ROM[0x10..0x13]={0x001,0x002,0x003,0x1FF}, start_addr=0x10, instr_ready=1 -> instr 0x001..0x1FF on 4 consecutive cycles, instr_pc 0x10..0x13, then done=1, busy=0, pc=0x13.
- Backpressure: same program, instr_ready=0 for 3 cycles after first valid -> instr=0x001/instr_pc=0x10 held, pc stays 0x11. Release -> 0x002 next cycle, no word lost or duplicated.
- Redirect: ROM[0x40]=0x055, br_taken with br_target=0x40 while slot holds pc 0x11 -> slot flushed, one bubble, then instr=0x055, instr_pc=0x40.
- Branch-over-halt: br_taken with br_target=0x20 in DRAIN -> halt never transferred, state RUN, fetch resumes at 0x20.
- Wrap: start_addr=0xFFFF, ROM[0xFFFF]=0x00A, ROM[0]=0x00B -> instr_pc 0xFFFF then 0x0000.
- Reset: rst_n=0 for 1 cycle mid-RUN with slot valid -> next cycle instr_valid=0, state IDLE, pc=0, done=0. Restart at 0x10 reproduces the straight-line result. With FETCH_PERF_CNT_EN, straight-line gives fetch_cnt=4, flush_cnt=0, stall_cnt=0.
